layer2_neuron_engine: RTL and testbench

Sequencer and MAC datapath for fully connected layer 2. Drives `neuron_index` into `rom_layer2`, consumes its registered `neuron_weights_flat`, and takes a dot product of each neuron's int8 weight row with a latched int8 activation vector. It then applies an arithmetic right shift, ReLU and saturation to int8, and writes one output per neuron into a flat layer-output register. It sits directly downstream of the layer-2 weight ROM and upstream of the next layer / argmax stage.

---
 rtl/layer2_neuron_engine_if.sv | 34 +++
 rtl/layer2_neuron_engine.sv | 151 +++++++++++++++
 tb/tb_layer2_neuron_engine.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer2_neuron_engine_if.sv
// Bus bundle between the layer-2 engine, its weight ROM, the activation source
// and the downstream consumer of the layer outputs.
interface layer2_neuron_engine_if #(
    parameter int NUM_NEURONS = 16,
    parameter int NUM_INPUTS  = 30
) ();
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    // start is a level request, honoured only while the engine is idle (busy=0);
    // out_valid/done are single-cycle pulses with no backpressure; the ROM must
    // present the row for neuron_index one clock after neuron_index changes.
    logic                      start;
    logic [NUM_INPUTS*8-1:0]   in_activations_flat;
    logic [IW-1:0]             neuron_index;
    logic [NUM_INPUTS*8-1:0]   neuron_weights_flat;
    logic                      busy;
    logic                      out_valid;
    logic [IW-1:0]             out_index;
    logic [7:0]                out_value;
    logic [NUM_NEURONS*8-1:0]  layer_out_flat;
    logic                      done;

    modport master (
        output start, in_activations_flat, neuron_weights_flat,
        input  neuron_index, busy, out_valid, out_index, out_value,
               layer_out_flat, done
    );

    modport slave (
        input  start, in_activations_flat, neuron_weights_flat,
        output neuron_index, busy, out_valid, out_index, out_value,
               layer_out_flat, done
    );
endinterface

// File: rtl/layer2_neuron_engine.sv
// Fully connected layer-2 engine: one int8 dot product per neuron, then
// arithmetic shift, ReLU and saturation to 0..127, stored per neuron.
module layer2_neuron_engine #(
    parameter int NUM_NEURONS = 16,
    parameter int NUM_INPUTS  = 30,
    parameter int ACC_WIDTH   = 24,
    parameter int SHIFT       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    layer2_neuron_engine_if.slave  bus,
    output logic [1:0]             dbg_state_o
);
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int KW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int AW = NUM_INPUTS * 8;
    localparam int LW = NUM_NEURONS * 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MAC   = 2'd2,
        S_ACT   = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [AW-1:0]                act_q, act_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [KW-1:0]                k_q, k_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic                         out_valid_q, out_valid_d;
    logic [IW-1:0]                out_index_q, out_index_d;
    logic [7:0]                   out_value_q, out_value_d;
    logic [LW-1:0]                layer_q, layer_d;
    logic                         done_q, done_d;

    logic [KW+2:0]                k_bit;
    logic [IW+2:0]                idx_bit;
    logic signed [7:0]            w_k;
    logic signed [7:0]            a_k;
    logic signed [15:0]           prod;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [7:0]                   act_result;

    // Datapath: select element k, multiply, and requantize the finished sum.
    always_comb begin
        k_bit   = {k_q, 3'b000};
        idx_bit = {idx_q, 3'b000};
        w_k     = bus.neuron_weights_flat[k_bit +: 8];
        a_k     = act_q[k_bit +: 8];
        prod    = w_k * a_k;
        shifted = acc_q >>> SHIFT;
        if (shifted[ACC_WIDTH-1]) begin
            act_result = 8'd0;
        end else if (|shifted[ACC_WIDTH-2:7]) begin
            act_result = 8'd127;
        end else begin
            act_result = {1'b0, shifted[6:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        acc_d       = acc_q;
        k_d         = k_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_index_d = out_index_q;
        out_value_d = out_value_q;
        layer_d     = layer_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    act_d   = bus.in_activations_flat;
                    layer_d = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_FETCH;
                end
            end
            // The ROM registers the row for idx_q during this cycle.
            S_FETCH: begin
                acc_d   = '0;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + {{(ACC_WIDTH-16){prod[15]}}, prod};
                if (k_q == KW'(NUM_INPUTS - 1)) begin
                    state_d = S_ACT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_ACT: begin
                out_value_d            = act_result;
                out_index_d            = idx_q;
                out_valid_d            = 1'b1;
                layer_d[idx_bit +: 8]  = act_result;
                if (idx_q == IW'(NUM_NEURONS - 1)) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            act_q       <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_value_q <= '0;
            layer_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_value_q <= out_value_d;
            layer_q     <= layer_d;
            done_q      <= done_d;
        end
    end

    assign bus.neuron_index   = idx_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.out_index      = out_index_q;
    assign bus.out_value      = out_value_q;
    assign bus.layer_out_flat = layer_q;
    assign bus.done           = done_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_layer2_neuron_engine.sv
// Bench for layer2_neuron_engine: registered ROM model, fixed-pattern table,
// random layers against a plain-arithmetic reference, reset and restart cases.
module tb_layer2_neuron_engine;
    localparam int NN    = 16;
    localparam int NI    = 30;
    localparam int SHIFT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [NI*8-1:0] rom_mem [NN];
    logic [NI*8-1:0] act_vec;
    logic [7:0]      exp_q [$];
    logic [7:0]      exp_layer [NN];
    logic [7:0]      got_vals [NN];

    typedef struct {
        int w_val;
        bit w_row;
        int a_val;
        int exp0;
        int exp8;
        int exp15;
    } vec_t;

    vec_t vecs [5];

    layer2_neuron_engine_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) bus ();

    layer2_neuron_engine #(
        .NUM_NEURONS(NN),
        .NUM_INPUTS (NI),
        .ACC_WIDTH  (24),
        .SHIFT      (SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Weight ROM: row appears one clock after the index.
    always @(posedge clk) bus.neuron_weights_flat <= rom_mem[bus.neuron_index];

    int state_changes = 0;
    logic [1:0] prev_state = 2'd0;
    always @(posedge clk) begin
        if (dbg_state != prev_state) state_changes++;
        prev_state <= dbg_state;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},      int'(bus.busy), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_done"},      int'(bus.done), 0);
        check({tag, "_index"},     int'(bus.neuron_index), 0);
        check({tag, "_out_index"}, int'(bus.out_index), 0);
        check({tag, "_out_value"}, int'(bus.out_value), 0);
        for (int n = 0; n < NN; n++)
            check({tag, "_layer"}, int'(bus.layer_out_flat[n*8 +: 8]), 0);
    endtask

    function automatic void build_expected();
        int sum;
        int r;
        exp_q.delete();
        for (int n = 0; n < NN; n++) begin
            sum = 0;
            for (int k = 0; k < NI; k++)
                sum += int'($signed(rom_mem[n][k*8 +: 8])) * int'($signed(act_vec[k*8 +: 8]));
            r = sum >>> SHIFT;
            if (r < 0) r = 0;
            else if (r > 127) r = 127;
            exp_q.push_back(8'(r));
        end
    endfunction

    task automatic fill_const(input int w_val, input bit w_row, input int a_val);
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++)
                rom_mem[n][k*8 +: 8] = 8'(w_row ? n : w_val);
        for (int k = 0; k < NI; k++) act_vec[k*8 +: 8] = 8'(a_val);
    endtask

    task automatic fill_random(input int lo, input int unsigned span);
        int v;
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++) begin
                v = lo + int'($urandom_range(0, span));
                rom_mem[n][k*8 +: 8] = 8'(v);
            end
        for (int k = 0; k < NI; k++) begin
            v = lo + int'($urandom_range(0, span));
            act_vec[k*8 +: 8] = 8'(v);
        end
    endtask

    // Runs one layer; observation point is #1 after each posedge, cycle 1 being
    // the first cycle after start was sampled.
    task automatic run_layer(input bit noise, input int reset_at, input bit chain);
        int cyc;
        int dones;
        int exp_idx;
        bit vexp;
        logic [7:0] ev;
        build_expected();
        for (int n = 0; n < NN; n++) begin
            exp_layer[n] = 8'h00;
            got_vals[n]  = 8'hff;
        end
        dones = 0;
        @(negedge clk);
        bus.in_activations_flat = act_vec;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= 520) begin
            if (reset_at != 0 && cyc == reset_at + 1) begin
                check_idle_zero("post_reset");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (chain && cyc == 514) begin
                check("chain_busy",  int'(bus.busy), 1);
                check("chain_index", int'(bus.neuron_index), 0);
                check("chain_valid", int'(bus.out_valid), 0);
                for (int n = 0; n < NN; n++)
                    check("chain_layer_cleared", int'(bus.layer_out_flat[n*8 +: 8]), 0);
                @(negedge clk);
                bus.start = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            check("busy", int'(bus.busy), int'(cyc <= 512));
            check("done", int'(bus.done), int'(cyc == 513));
            if (bus.done) dones++;
            exp_idx = (cyc <= 512) ? (cyc - 1) / 32 : 0;
            check("neuron_index", int'(bus.neuron_index), exp_idx);
            vexp = (cyc >= 33) && (cyc <= 513) && ((cyc - 33) % 32 == 0);
            check("out_valid", int'(bus.out_valid), int'(vexp));
            if (vexp) begin
                check("out_index", int'(bus.out_index), (cyc - 33) / 32);
                ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hee;
                check("out_value", int'(bus.out_value), int'(ev));
                got_vals[(cyc - 33) / 32] = bus.out_value;
                exp_layer[(cyc - 33) / 32] = ev;
            end
            if (vexp || cyc == 1) begin
                for (int n = 0; n < NN; n++)
                    check("layer_byte", int'(bus.layer_out_flat[n*8 +: 8]), int'(exp_layer[n]));
            end

            @(negedge clk);
            if (noise && cyc >= 5 && cyc <= 400) begin
                bus.start = 1'($urandom_range(0, 1));
                for (int k = 0; k < NI; k++)
                    bus.in_activations_flat[k*8 +: 8] = 8'($urandom_range(0, 255));
            end else if (noise && cyc == 401) begin
                bus.start = 1'b0;
                bus.in_activations_flat = act_vec;
            end
            if (reset_at != 0 && cyc == reset_at) rst_n = 1'b0;
            if (chain && cyc == 513) bus.start = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_count", dones, 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{w_val: 1,    w_row: 1'b0, a_val: 4,    exp0: 7,   exp8: 7,   exp15: 7};
        vecs[1] = '{w_val: 127,  w_row: 1'b0, a_val: 127,  exp0: 127, exp8: 127, exp15: 127};
        vecs[2] = '{w_val: -1,   w_row: 1'b0, a_val: 4,    exp0: 0,   exp8: 0,   exp15: 0};
        vecs[3] = '{w_val: 0,    w_row: 1'b1, a_val: 1,    exp0: 0,   exp8: 15,  exp15: 28};
        vecs[4] = '{w_val: -128, w_row: 1'b0, a_val: -128, exp0: 127, exp8: 127, exp15: 127};

        bus.start = 1'b0;
        bus.in_activations_flat = '0;
        fill_const(0, 1'b0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_hold_busy", int'(bus.busy), 0);

        for (int i = 0; i < 5; i++) begin
            fill_const(vecs[i].w_val, vecs[i].w_row, vecs[i].a_val);
            run_layer(1'b0, 0, 1'b0);
            check("table_n0",  int'(got_vals[0]),  vecs[i].exp0);
            check("table_n8",  int'(got_vals[8]),  vecs[i].exp8);
            check("table_n15", int'(got_vals[15]), vecs[i].exp15);
        end

        // start and activation churn while busy must not disturb the run
        fill_const(1, 1'b0, 4);
        run_layer(1'b1, 0, 1'b0);
        for (int n = 0; n < NN; n++) check("noise_value", int'(got_vals[n]), 7);

        // reset mid-MAC, then a clean run with different data
        fill_const(1, 1'b0, 4);
        run_layer(1'b0, 100, 1'b0);
        fill_const(0, 1'b1, 1);
        run_layer(1'b0, 0, 1'b0);
        check("after_reset_n15", int'(got_vals[15]), 28);

        // start in the done cycle is accepted
        fill_const(1, 1'b0, 4);
        run_layer(1'b0, 0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            fill_random(-128, 255);
            run_layer(1'b0, 0, 1'b0);
            fill_random(-6, 12);
            run_layer(1'b0, 0, 1'b0);
        end

        $display("state transitions observed %0d", state_changes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
